gate_bist_ctrl: RTL and testbench

Built-in self-test controller for the NAND-derived gate bank: and, or, xor, not, nand and nor. On request, it drives the bank's shared `a`/`b` inputs through all four input vectors and waits a programmable settle time after each one. It then checks all six gate outputs against their truth tables and reports a per-gate fail mask plus an overall pass flag. It sits between the test/bring-up logic and the gate bank, and is the only driver of the bank's inputs.

---
 rtl/gate_bist_ctrl_pkg.sv | 32 +++
 rtl/gate_bist_ctrl_if.sv | 30 +++
 rtl/gate_bist_ctrl_gate_bank.sv | 36 +++
 rtl/gate_bist_ctrl.sv | 114 +++++++++++
 tb/tb_gate_bist_ctrl.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/gate_bist_ctrl_pkg.sv
// Shared types and constants for the gate-bank self-test controller.
// No ports. Provides the FSM state type, the gate bit positions, the
// per-vector expected bank response and the gate count.
package gate_bist_pkg;

  localparam int N_GATES = 6;

  localparam int G_AND  = 0;
  localparam int G_OR   = 1;
  localparam int G_XOR  = 2;
  localparam int G_NOT  = 3;
  localparam int G_NAND = 4;
  localparam int G_NOR  = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } state_e;

  // Expected {nor, nand, not, xor, or, and} per vector index {a, b}.
  // NOT is taken from input a. Entries are the true gate truth tables,
  // so a fault-free bank reports an empty fail mask.
  localparam logic [3:0][N_GATES-1:0] EXP_PATTERN = {
    6'b000011,   // vec3: a=1 b=1
    6'b010110,   // vec2: a=1 b=0
    6'b011110,   // vec1: a=0 b=1
    6'b111000    // vec0: a=0 b=0
  };

endpackage

// File: rtl/gate_bist_ctrl_if.sv
// Bundle between the test/bring-up side, the gate bank and the BIST
// controller.
//   master: drives start_i, abort_i and the bank response gate_q_i;
//           observes bank inputs and run status.
//   slave : the controller.
interface gate_bist_ctrl_if;
  import gate_bist_pkg::*;

  logic               start_i;
  logic               abort_i;
  logic [N_GATES-1:0] gate_q_i;
  logic               a_o;
  logic               b_o;
  logic [1:0]         vec_idx_o;
  logic               busy_o;
  logic               done_o;
  logic               pass_o;
  logic [N_GATES-1:0] fail_mask_o;

  modport master (
    output start_i, abort_i, gate_q_i,
    input  a_o, b_o, vec_idx_o, busy_o, done_o, pass_o, fail_mask_o
  );

  modport slave (
    input  start_i, abort_i, gate_q_i,
    output a_o, b_o, vec_idx_o, busy_o, done_o, pass_o, fail_mask_o
  );

endinterface

// File: rtl/gate_bist_ctrl_gate_bank.sv
// The gate bank under test: and, or, xor, not, nand, nor, all built from
// two-input NAND terms.
//   a, b : shared bank inputs
//   q    : {nor, nand, not, xor, or, and}; NOT is of input a
module gate_bank
  import gate_bist_pkg::*;
(
  input  logic               a,
  input  logic               b,
  output logic [N_GATES-1:0] q
);

  function automatic logic nand2(input logic x, input logic y);
    return ~(x & y);
  endfunction

  logic n_ab, n_a, n_b, n_or, x_l, x_r;

  assign n_ab = nand2(a, b);
  assign n_a  = nand2(a, a);
  assign n_b  = nand2(b, b);
  assign n_or = nand2(n_a, n_b);
  assign x_l  = nand2(a, n_ab);
  assign x_r  = nand2(b, n_ab);

  always_comb begin
    q         = '0;
    q[G_AND]  = nand2(n_ab, n_ab);
    q[G_OR]   = n_or;
    q[G_XOR]  = nand2(x_l, x_r);
    q[G_NOT]  = n_a;
    q[G_NAND] = n_ab;
    q[G_NOR]  = nand2(n_or, n_or);
  end

endmodule

// File: rtl/gate_bist_ctrl.sv
// BIST controller for the gate bank. Walks the four {a,b} vectors, holds
// each for SETTLE_CYCLES, samples the bank and accumulates a sticky
// per-gate fail mask; pulses done_o with pass_o at the end of a run.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of gate_bist_ctrl_if (start/abort in, bank
//                response in, bank drive and run status out)
// SETTLE_CYCLES legal range 1..15.
module gate_bist_ctrl
  import gate_bist_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  gate_bist_ctrl_if.slave  bus
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [1:0]         vec_q, vec_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic [N_GATES-1:0] fail_q, fail_d;
  logic [N_GATES-1:0] mism;
  logic [N_GATES-1:0] fail_acc;

  assign mism     = bus.gate_q_i ^ EXP_PATTERN[vec_q];
  assign fail_acc = fail_q | mism;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    fail_d  = fail_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start_i) begin
          state_d = ST_SETTLE;
          cnt_d   = SETTLE_LOAD;
          vec_d   = 2'd0;
          busy_d  = 1'b1;
          pass_d  = 1'b0;
          fail_d  = '0;
        end
      end
      ST_SETTLE, ST_CHECK: begin
        if (bus.abort_i) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          vec_d   = 2'd0;
          busy_d  = 1'b0;
          pass_d  = 1'b0;
          fail_d  = '0;
        end else if (state_q == ST_SETTLE) begin
          if (cnt_q == '0) state_d = ST_CHECK;
          else             cnt_d   = cnt_q - 4'd1;
        end else begin
          fail_d = fail_acc;
          if (vec_q == 2'd3) begin
            state_d = ST_DONE;
            vec_d   = 2'd0;
            done_d  = 1'b1;
            pass_d  = (fail_acc == '0);
          end else begin
            state_d = ST_SETTLE;
            vec_d   = vec_q + 2'd1;
            cnt_d   = SETTLE_LOAD;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      vec_q   <= 2'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
    end
  end

  // vec_q is forced to 0 outside SETTLE/CHECK, so the bank sees 00 when idle.
  assign bus.a_o         = vec_q[1];
  assign bus.b_o         = vec_q[0];
  assign bus.vec_idx_o   = vec_q;
  assign bus.busy_o      = busy_q;
  assign bus.done_o      = done_q;
  assign bus.pass_o      = pass_q;
  assign bus.fail_mask_o = fail_q;

endmodule

// File: tb/tb_gate_bist_ctrl.sv
module tb_gate_bist_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gate_bist_ctrl_if bus2 ();
  gate_bist_ctrl_if bus1 ();

  logic [5:0] bq2, bq1;
  logic [5:0] sa0 = '0, sa1 = '0, inv = '0;

  gate_bank u_bank2 (.a(bus2.a_o), .b(bus2.b_o), .q(bq2));
  gate_bank u_bank1 (.a(bus1.a_o), .b(bus1.b_o), .q(bq1));

  assign bus2.gate_q_i = ((bq2 & ~sa0) | sa1) ^ inv;
  assign bus1.gate_q_i = ((bq1 & ~sa0) | sa1) ^ inv;

  gate_bist_ctrl #(.SETTLE_CYCLES(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
  gate_bist_ctrl #(.SETTLE_CYCLES(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  int checks = 0;
  int errors = 0;

  // Ideal gate outputs {nor, nand, not(a), xor, or, and}.
  function automatic logic [5:0] truth(input logic a, input logic b);
    return {~(a | b), ~(a & b), ~a, a ^ b, a | b, a & b};
  endfunction

  function automatic logic [5:0] mism(input int k);
    logic a, b;
    logic [5:0] t;
    a = (k >= 2);
    b = (k % 2 == 1);
    t = truth(a, b);
    return (((t & ~sa0) | sa1) ^ inv) ^ t;
  endfunction

  // {busy, done, pass, a, b, vec[1:0], fail[5:0]} expected l cycles after
  // the start-sampling edge, derived from the run timeline.
  function automatic logic [12:0] model(input int s, input int l);
    int p, n, v;
    logic busy, done, pass;
    logic [1:0] vv;
    logic [5:0] fail, all;
    p = s + 1;
    n = 4 * p;
    all = mism(0) | mism(1) | mism(2) | mism(3);
    v = 0; busy = 0; done = 0; pass = 0; fail = '0;
    if (l <= n) begin
      busy = 1;
      v = (l - 1) / p;
      for (int k = 0; k < 4; k++)
        if ((k + 1) * p <= l - 1) fail |= mism(k);
    end else begin
      busy = (l == n + 1);
      done = (l == n + 1);
      fail = all;
      pass = (all == 6'd0);
    end
    vv = 2'(v);
    return {busy, done, pass, vv[1], vv[0], vv, fail};
  endfunction

  function automatic logic [12:0] obs(input int sel);
    if (sel == 1)
      return {bus1.busy_o, bus1.done_o, bus1.pass_o, bus1.a_o, bus1.b_o,
              bus1.vec_idx_o, bus1.fail_mask_o};
    return {bus2.busy_o, bus2.done_o, bus2.pass_o, bus2.a_o, bus2.b_o,
            bus2.vec_idx_o, bus2.fail_mask_o};
  endfunction

  task automatic drive(input int sel, input logic st, input logic ab);
    if (sel == 1) begin bus1.start_i = st; bus1.abort_i = ab; end
    else          begin bus2.start_i = st; bus2.abort_i = ab; end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int l, input logic [12:0] o,
                       input logic [12:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s l=%0d observed=%b expected=%b", tag, l, o, e);
    end
  endtask

  // One run on DUT sel: optional abort after label abort_at, optional
  // ignored start pulse after label restart_at, optional abort with start.
  task automatic run(input string tag, input int sel, input int abort_at,
                     input logic abort_with_start, input int restart_at);
    int s, n;
    s = (sel == 1) ? 1 : 2;
    n = 4 * (s + 1);
    drive(sel, 1'b1, abort_with_start);
    tick();
    drive(sel, 1'b0, 1'b0);
    for (int l = 1; l <= n + 2; l++) begin
      check(tag, l, obs(sel), model(s, l));
      if (l == abort_at) begin
        drive(sel, 1'b0, 1'b1);
        tick();
        drive(sel, 1'b0, 1'b0);
        for (int j = 0; j < 3; j++) begin
          check({tag, "_abort"}, l + 1 + j, obs(sel), 13'd0);
          tick();
        end
        return;
      end
      if (l == restart_at) drive(sel, 1'b1, 1'b0);
      tick();
      drive(sel, 1'b0, 1'b0);
    end
  endtask

  initial begin
    int busy_low;
    drive(1, 1'b0, 1'b0);
    drive(2, 1'b0, 1'b0);
    #12;
    check("reset_s2", 0, obs(2), 13'd0);
    check("reset_s1", 0, obs(1), 13'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    run("good_s2", 2, 0, 1'b0, 0);

    sa0 = 6'b000001;
    run("and_sa0", 2, 0, 1'b0, 0);
    check("and_sa0_mask", 0, {7'd0, bus2.fail_mask_o}, {7'd0, 6'b000001});

    sa0 = '0; inv = 6'b000100; sa1 = 6'b001000;
    run("xnor_not1", 2, 0, 1'b0, 0);
    check("xnor_not1_mask", 0, {7'd0, bus2.fail_mask_o}, {7'd0, 6'b001100});
    inv = '0; sa1 = '0;

    // start held high: back-to-back runs, busy low for one cycle between.
    busy_low = 0;
    drive(2, 1'b1, 1'b0);
    tick();
    for (int l = 1; l <= 28; l++) begin
      check("held_start", l, obs(2), model(2, (l - 1) % 14 + 1));
      if (!bus2.busy_o) busy_low++;
      if (l == 20) drive(2, 1'b0, 1'b0);
      tick();
    end
    check("held_busy_low", 0, 13'(busy_low), 13'd2);

    run("abort_t5", 2, 5, 1'b0, 0);
    run("abort_last_check", 2, 12, 1'b0, 0);
    run("start_abort_idle", 2, 0, 1'b1, 0);
    run("start_while_busy", 2, 0, 1'b0, 4);

    for (int i = 0; i < 12; i++) begin
      int sel, n, ab;
      sel = $urandom_range(1, 2);
      n = (sel == 1) ? 8 : 12;
      sa0 = 6'($urandom) & 6'($urandom);
      sa1 = 6'($urandom) & 6'($urandom) & 6'($urandom);
      inv = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0;
      ab = ($urandom_range(0, 1) == 1) ? $urandom_range(1, n) : 0;
      run("random", sel, ab, 1'($urandom), $urandom_range(0, n));
    end
    sa0 = '0; sa1 = '0; inv = '0;

    // Reset mid-SETTLE of vector 2.
    drive(2, 1'b1, 1'b0);
    tick();
    drive(2, 1'b0, 1'b0);
    for (int l = 1; l <= 7; l++) begin
      check("pre_reset", l, obs(2), model(2, l));
      if (l < 7) tick();
    end
    rst_n = 1'b0;
    #1;
    check("mid_reset", 0, obs(2), 13'd0);
    tick();
    check("mid_reset_hold", 0, obs(2), 13'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run("post_reset", 2, 0, 1'b0, 0);

    run("good_s1", 1, 0, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
